// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: reset/enable levels and FSM state encodings for the hazard controller
package pipe_ctrl_pkg;
    localparam logic RESET  = 1'b1;
    localparam logic ENABLE = 1'b1;
    typedef enum logic [1:0] {
        PCTRL_RUN   = 2'd0,
        PCTRL_DIV   = 2'd1,
        PCTRL_DRAIN = 2'd2,
        PCTRL_REDIR = 2'd3
    } state_t;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs from the core and stage-register controls back to it
interface pipe_ctrl_if;
    logic       ld_use_hazard_i, br_taken_i, div_start_i, div_done_i, mem_wait_i, trap_req_i;
    logic       pc_we_o, ifid_stall_o, idex_stall_o, exmem_stall_o;
    logic       ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o;
    logic       trap_ack_o, bus_err_o;
    logic [1:0] state_o;
    modport master (
        input  ld_use_hazard_i, br_taken_i, div_start_i, div_done_i, mem_wait_i, trap_req_i,
        output pc_we_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
               ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o,
               trap_ack_o, bus_err_o, state_o
    );
    modport slave (
        output ld_use_hazard_i, br_taken_i, div_start_i, div_done_i, mem_wait_i, trap_req_i,
        input  pc_we_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
               ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o,
               trap_ack_o, bus_err_o, state_o
    );
endinterface

// File: rtl/pipe_ctrl_stall_wdt.sv
// pipe_ctrl_stall_wdt: counts consecutive mem-wait cycles, pulses bus_err_o on the STALL_MAX-th
module pipe_ctrl_stall_wdt
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_MAX = 15,
    parameter int CW        = 4
) (
    input  logic clk,
    input  logic rest,
    input  logic mem_wait_i,
    output logic bus_err_o
);
    logic [CW-1:0] cnt;
    logic          expire;
    assign expire    = mem_wait_i && cnt == CW'(STALL_MAX - 1);
    assign bus_err_o = expire && rest != RESET;
    always_ff @(posedge clk)
        if (rest == RESET || !mem_wait_i || expire) cnt <= '0;
        else cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller producing stall/flush/PC-enable for the five-stage core
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TRAP_DRAIN = 2,
    parameter int STALL_MAX  = 15,
    parameter int CW         = 4
) (
    input logic        clk,
    input logic        rest,
    pipe_ctrl_if.master bus
);
    state_t        state, state_nx;
    logic [CW-1:0] drain_cnt, drain_nx;
    logic pc_we, ifid_s, idex_s, exmem_s, ifid_f, idex_f, exmem_f, memwb_f, trap_ack, wdt_err;

    pipe_ctrl_stall_wdt #(.STALL_MAX(STALL_MAX), .CW(CW)) u_wdt (
        .clk        (clk),
        .rest       (rest),
        .mem_wait_i (bus.mem_wait_i),
        .bus_err_o  (wdt_err)
    );

    always_ff @(posedge clk)
        if (rest == RESET) begin
            state     <= PCTRL_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_nx;
        end

    always_comb begin
        pc_we    = ENABLE;
        ifid_s   = 1'b0;
        idex_s   = 1'b0;
        exmem_s  = 1'b0;
        ifid_f   = 1'b0;
        idex_f   = 1'b0;
        exmem_f  = 1'b0;
        memwb_f  = 1'b0;
        trap_ack = 1'b0;
        state_nx = state;
        drain_nx = drain_cnt;
        case (state)
            PCTRL_RUN:
                if (bus.trap_req_i) begin
                    pc_we = 1'b0; ifid_f = 1'b1; idex_f = 1'b1;
                    state_nx = PCTRL_DRAIN; drain_nx = '0;
                end else if (bus.mem_wait_i) begin
                    pc_we = 1'b0; ifid_s = 1'b1; idex_s = 1'b1; exmem_s = 1'b1; memwb_f = 1'b1;
                end else if (bus.br_taken_i) begin
                    ifid_f = 1'b1; idex_f = 1'b1;
                end else if (bus.div_start_i) begin
                    pc_we = 1'b0; ifid_s = 1'b1; idex_s = 1'b1; exmem_f = 1'b1;
                    state_nx = PCTRL_DIV;
                end else if (bus.ld_use_hazard_i) begin
                    pc_we = 1'b0; ifid_s = 1'b1; idex_f = 1'b1;
                end
            PCTRL_DIV:
                // Completion releases the pipe in the same cycle the result is valid
                if (bus.div_done_i) state_nx = PCTRL_RUN;
                else begin
                    pc_we = 1'b0; ifid_s = 1'b1; idex_s = 1'b1;
                    exmem_s = bus.mem_wait_i; memwb_f = bus.mem_wait_i; exmem_f = !bus.mem_wait_i;
                end
            PCTRL_DRAIN: begin
                pc_we = 1'b0; ifid_f = 1'b1; idex_f = 1'b1;
                exmem_s = bus.mem_wait_i; memwb_f = bus.mem_wait_i;
                if (!bus.mem_wait_i) begin
                    drain_nx = drain_cnt + 1'b1;
                    state_nx = drain_cnt == CW'(TRAP_DRAIN - 1) ? PCTRL_REDIR : PCTRL_DRAIN;
                end
            end
            default: begin
                trap_ack = 1'b1; ifid_f = 1'b1; idex_f = 1'b1; exmem_f = 1'b1;
                state_nx = PCTRL_RUN;
            end
        endcase
        if (rest == RESET) begin
            pc_we = 1'b0; ifid_s = 1'b0; idex_s = 1'b0; exmem_s = 1'b0; trap_ack = 1'b0;
            ifid_f = 1'b1; idex_f = 1'b1; exmem_f = 1'b1; memwb_f = 1'b1;
        end
    end

    assign bus.pc_we_o       = pc_we;
    assign bus.ifid_stall_o  = ifid_s;
    assign bus.idex_stall_o  = idex_s;
    assign bus.exmem_stall_o = exmem_s;
    assign bus.ifid_flush_o  = ifid_f;
    assign bus.idex_flush_o  = idex_f;
    assign bus.exmem_flush_o = exmem_f;
    assign bus.memwb_flush_o = memwb_f;
    assign bus.trap_ack_o    = trap_ack;
    assign bus.bus_err_o     = wdt_err;
    assign bus.state_o       = rest == RESET ? PCTRL_RUN : state;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random hazard stimulus, scored against a cycle-level reference model
module tb_pipe_ctrl;
    localparam int TD = 2;
    localparam int SM = 15;

    typedef struct {
        logic [11:0] exp;
        string       tag;
    } item_t;

    logic  clk = 1'b0;
    logic  rest = 1'b1;
    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    mode = 0, drain_left = 0, wait_run = 0;

    pipe_ctrl_if bus();

    pipe_ctrl #(.TRAP_DRAIN(TD), .STALL_MAX(SM), .CW(4)) dut (
        .clk  (clk),
        .rest (rest),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] got();
        return {bus.pc_we_o, bus.ifid_stall_o, bus.idex_stall_o, bus.exmem_stall_o,
                bus.ifid_flush_o, bus.idex_flush_o, bus.exmem_flush_o, bus.memwb_flush_o,
                bus.trap_ack_o, bus.bus_err_o, bus.state_o};
    endfunction

    // Reference: mode 0 run, 1 divide, 2 drain (drain_left cycles to go), 3 redirect
    task automatic model(input bit rs, ld, br, ds, dd, mw, tr, output logic [11:0] e);
        bit pw, s1, s2, s3, f1, f2, f3, f4, ak, be;
        int st;
        pw = 1'b1;
        {s1, s2, s3, f1, f2, f3, f4, ak, be} = '0;
        st = mode;
        if (rs) begin
            pw = 1'b0; {f1, f2, f3, f4} = 4'hf; st = 0;
            mode = 0; drain_left = 0; wait_run = 0;
        end else begin
            wait_run = mw ? wait_run + 1 : 0;
            be = mw && (wait_run % SM == 0);
            case (mode)
                0: begin
                    if (tr) begin pw = 0; f1 = 1; f2 = 1; mode = 2; drain_left = TD; end
                    else if (mw) begin pw = 0; s1 = 1; s2 = 1; s3 = 1; f4 = 1; end
                    else if (br) begin f1 = 1; f2 = 1; end
                    else if (ds) begin pw = 0; s1 = 1; s2 = 1; f3 = 1; mode = 1; end
                    else if (ld) begin pw = 0; s1 = 1; f2 = 1; end
                end
                1: begin
                    if (dd) mode = 0;
                    else begin
                        pw = 0; s1 = 1; s2 = 1;
                        if (mw) begin s3 = 1; f4 = 1; end else f3 = 1;
                    end
                end
                2: begin
                    pw = 0; f1 = 1; f2 = 1;
                    if (mw) begin s3 = 1; f4 = 1; end
                    else begin
                        drain_left--;
                        if (drain_left == 0) mode = 3;
                    end
                end
                default: begin ak = 1; f1 = 1; f2 = 1; f3 = 1; mode = 0; end
            endcase
        end
        e = {pw, s1, s2, s3, f1, f2, f3, f4, ak, be, 2'(st)};
    endtask

    task automatic cyc(input bit rs, ld, br, ds, dd, mw, tr, input string tag);
        logic [11:0] e;
        @(posedge clk);
        #1;
        rest = rs;
        bus.ld_use_hazard_i = ld;
        bus.br_taken_i      = br;
        bus.div_start_i     = ds;
        bus.div_done_i      = dd;
        bus.mem_wait_i      = mw;
        bus.trap_req_i      = tr;
        model(rs, ld, br, ds, dd, mw, tr, e);
        sb.push_back('{e, tag});
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    always @(negedge clk) begin : monitor
        item_t it;
        if (sb.size() != 0) begin
            it = sb.pop_front();
            checks++;
            if (got() !== it.exp) begin
                errors++;
                $display("FAIL %s @%0t: got %b expected %b (pc_we,stall x3,flush x4,ack,err,state)",
                         it.tag, $time, got(), it.exp);
            end
        end
    end

    always @(negedge clk)
        assert (!(bus.br_taken_i && bus.div_start_i)) else $error("branch and divide issued together");

    initial begin
        bus.ld_use_hazard_i = 0; bus.br_taken_i = 0; bus.div_start_i = 0;
        bus.div_done_i = 0; bus.mem_wait_i = 0; bus.trap_req_i = 0;
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, "reset");
        idle(2, "release");
        cyc(0, 1, 0, 0, 0, 0, 0, "ld_use");
        idle(1, "ld_use_after");
        cyc(0, 1, 1, 0, 0, 0, 0, "br_over_ld");
        cyc(0, 0, 0, 1, 0, 0, 0, "div_start");
        cyc(0, 0, 0, 0, 0, 0, 0, "div_busy");
        cyc(0, 0, 0, 0, 0, 1, 0, "div_memwait");
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, "div_busy");
        cyc(0, 0, 0, 0, 1, 0, 0, "div_done");
        idle(1, "div_after");
        cyc(0, 0, 0, 0, 0, 0, 1, "trap");
        cyc(0, 0, 0, 0, 0, 1, 0, "drain_memwait");
        idle(4, "trap_redir");
        cyc(0, 0, 0, 1, 0, 0, 0, "div_start2");
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 1, "trap_in_div");
        cyc(0, 0, 0, 0, 1, 0, 1, "div_done_trap");
        cyc(0, 0, 0, 0, 0, 0, 1, "trap_deferred");
        idle(4, "trap_deferred_redir");
        repeat (16) cyc(0, 0, 0, 0, 0, 1, 0, "watchdog");
        idle(2, "watchdog_after");
        cyc(0, 0, 0, 0, 0, 0, 1, "trap_then_reset");
        idle(1, "drain");
        cyc(1, 0, 0, 0, 0, 0, 0, "reset_mid_drain");
        idle(4, "no_ack_after_reset");
        for (int i = 0; i < 3000; i++) begin
            bit br, ds;
            br = $urandom_range(0, 9) == 0;
            ds = !br && $urandom_range(0, 9) == 0;
            if (i % 500 == 250) repeat (17) cyc(0, 0, 0, 0, 0, 1, 0, "rand_wdt");
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0, br, ds,
                $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3,
                $urandom_range(0, 11) == 0, "rand");
        end
        idle(2, "tail");
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
